// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Holds the FSM state encoding, the NOP pattern and the register-file write-select code for RAM data.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_MEMW = 1'b1
   } hz_state_t;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam logic [1:0]  RF_WSEL_RAM = 2'd1;

   // A source operand collides with a pending write only if it is actually read.
   function automatic logic reg_hit(input logic used, input logic [4:0] rs, input logic [4:0] rd);
      return used && (rs == rd);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard information from the pipeline stages and the stall/flush controls returned to them.
// The "pipe" side drives hazard sources; the "ctrl" side is the sequencer.
interface pipe_hazard_ctrl_if;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_rs1_used;
   logic       id_rs2_used;
   logic [4:0] ex_wR;
   logic       ex_is_load;
   logic       ex_redirect;
   logic       mem_req;
   logic       mem_ready;

   logic       pc_stall;
   logic       pc_redirect_en;
   logic       if_id_stall;
   logic       if_id_flush;
   logic       id_ex_stall;
   logic       id_ex_flush;
   logic       ex_mem_stall;
   logic       mem_wb_flush;

   modport pipe (
      output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_wR, ex_is_load,
             ex_redirect, mem_req, mem_ready,
      input  pc_stall, pc_redirect_en, if_id_stall, if_id_flush,
             id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush
   );

   modport ctrl (
      input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_wR, ex_is_load,
             ex_redirect, mem_req, mem_ready,
      output pc_stall, pc_redirect_en, if_id_stall, if_id_flush,
             id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hz_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module hz_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (inc && (q != {CNT_W{1'b1}})) begin
         q <= q + CNT_W'(1);
      end
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for PC and the four pipeline registers: data-RAM waits beat EX redirects,
// which beat load-use hazards. Also tracks stall/flush counts and a sticky RAM-timeout error.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   pipe_hazard_ctrl_if.ctrl hz,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);
   localparam int            TW     = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

   hz_state_t     state_reg;
   logic [TW-1:0] tcnt_reg;
   logic          timeout_hit;
   logic          memw;
   logic          lu;
   logic          br;

   always_comb begin
      // The timeout cycle releases the stall just like mem_ready would.
      timeout_hit = (state_reg == S_MEMW) && (tcnt_reg == T_LAST);
      memw        = hz.mem_req && !hz.mem_ready && !timeout_hit;
      br          = hz.ex_redirect;
      lu          = hz.ex_is_load && (hz.ex_wR != 5'd0) &&
                    (reg_hit(hz.id_rs1_used, hz.id_rs1, hz.ex_wR) ||
                     reg_hit(hz.id_rs2_used, hz.id_rs2, hz.ex_wR));

      hz.pc_stall       = 1'b0;
      hz.pc_redirect_en = 1'b0;
      hz.if_id_stall    = 1'b0;
      hz.if_id_flush    = 1'b0;
      hz.id_ex_stall    = 1'b0;
      hz.id_ex_flush    = 1'b0;
      hz.ex_mem_stall   = 1'b0;
      hz.mem_wb_flush   = 1'b0;

      if (rst_n) begin
         if (memw) begin
            hz.pc_stall     = 1'b1;
            hz.if_id_stall  = 1'b1;
            hz.id_ex_stall  = 1'b1;
            hz.ex_mem_stall = 1'b1;
            hz.mem_wb_flush = 1'b1;
         end else if (br) begin
            hz.pc_redirect_en = 1'b1;
            hz.if_id_flush    = 1'b1;
            hz.id_ex_flush    = 1'b1;
         end else if (lu) begin
            hz.pc_stall    = 1'b1;
            hz.if_id_stall = 1'b1;
            hz.id_ex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_RUN;
         tcnt_reg  <= '0;
         mem_err   <= 1'b0;
      end else begin
         case (state_reg)
            S_RUN: begin
               tcnt_reg <= '0;
               if (memw) state_reg <= S_MEMW;
            end
            S_MEMW: begin
               if (hz.mem_ready) begin
                  state_reg <= S_RUN;
                  tcnt_reg  <= '0;
               end else if (!hz.mem_req || timeout_hit) begin
                  // Abandoned or stuck access: release the pipeline and flag it.
                  state_reg <= S_RUN;
                  tcnt_reg  <= '0;
                  mem_err   <= 1'b1;
               end else begin
                  tcnt_reg <= tcnt_reg + TW'(1);
               end
            end
            default: state_reg <= S_RUN;
         endcase
      end
   end

   logic             cnt_inc [2];
   logic [CNT_W-1:0] cnt_q   [2];

   assign cnt_inc[0] = hz.pc_stall;
   assign cnt_inc[1] = hz.pc_redirect_en;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         hz_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (cnt_inc[gi]),
            .q     (cnt_q[gi])
         );
      end
   endgenerate

   assign stall_cycles = cnt_q[0];
   assign flush_events = cnt_q[1];
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   localparam int CNT_W = 32;
   localparam int MEM_TIMEOUT = 4;

   logic clk;
   logic rst_n;
   logic mem_err;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_events;
   int checks = 0;
   int failures = 0;

   pipe_hazard_ctrl_if hz ();

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .hz           (hz),
      .mem_err      (mem_err),
      .stall_cycles (stall_cycles),
      .flush_events (flush_events)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end else begin
         $display("ok   %s: %0h", tag, act);
      end
   endtask

   // Packed view of the eight control outputs:
   // {pc_stall, pc_redirect_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
   function automatic logic [7:0] ctl();
      return {hz.pc_stall, hz.pc_redirect_en, hz.if_id_stall, hz.if_id_flush,
              hz.id_ex_stall, hz.id_ex_flush, hz.ex_mem_stall, hz.mem_wb_flush};
   endfunction

   localparam logic [7:0] C_NONE = 8'b0000_0000;
   localparam logic [7:0] C_LU   = 8'b1010_0100;
   localparam logic [7:0] C_BR   = 8'b0101_0100;
   localparam logic [7:0] C_MEMW = 8'b1010_1011;

   task automatic idle();
      hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_rs1_used = 1'b0; hz.id_rs2_used = 1'b0;
      hz.ex_wR = 5'd0; hz.ex_is_load = 1'b0; hz.ex_redirect = 1'b0;
      hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      hz.mem_req = 1'b1;
      hz.ex_redirect = 1'b1;
      #2;
      check("reset_ctl", {24'd0, ctl()}, {24'd0, C_NONE});
      check("reset_stall_cnt", stall_cycles, 32'd0);
      check("reset_flush_cnt", flush_events, 32'd0);
      check("reset_err", {31'd0, mem_err}, 32'd0);
      tick();
      idle();
      rst_n = 1'b1;
      #1;
      check("idle_ctl", {24'd0, ctl()}, {24'd0, C_NONE});

      // Load-use on rs1
      hz.ex_is_load = 1'b1; hz.ex_wR = 5'd5; hz.id_rs1 = 5'd5; hz.id_rs1_used = 1'b1;
      #1 check("lu_rs1_ctl", {24'd0, ctl()}, {24'd0, C_LU});
      tick(); idle();
      check("lu_stall_cnt", stall_cycles, 32'd1);

      // Load of x0 never stalls
      hz.ex_is_load = 1'b1; hz.ex_wR = 5'd0; hz.id_rs1 = 5'd0; hz.id_rs1_used = 1'b1;
      #1 check("lu_x0_ctl", {24'd0, ctl()}, {24'd0, C_NONE});
      // rs2 matches but unused
      hz.ex_wR = 5'd5; hz.id_rs1 = 5'd3; hz.id_rs2 = 5'd5; hz.id_rs2_used = 1'b0;
      #1 check("lu_rs2_unused_ctl", {24'd0, ctl()}, {24'd0, C_NONE});
      hz.id_rs2_used = 1'b1;
      #1 check("lu_rs2_ctl", {24'd0, ctl()}, {24'd0, C_LU});
      tick(); idle();
      check("lu2_stall_cnt", stall_cycles, 32'd2);

      // Redirect beats load-use
      hz.ex_is_load = 1'b1; hz.ex_wR = 5'd7; hz.id_rs1 = 5'd7; hz.id_rs1_used = 1'b1;
      hz.ex_redirect = 1'b1;
      #1 check("br_over_lu_ctl", {24'd0, ctl()}, {24'd0, C_BR});
      tick(); idle();
      check("br_flush_cnt", flush_events, 32'd1);
      check("br_stall_cnt", stall_cycles, 32'd2);

      // RAM wait 3 cycles with a redirect pending in EX
      hz.mem_req = 1'b1; hz.ex_redirect = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check($sformatf("memw_ctl_%0d", i), {24'd0, ctl()}, {24'd0, C_MEMW});
         tick();
      end
      hz.mem_ready = 1'b1;
      #1 check("memw_release_ctl", {24'd0, ctl()}, {24'd0, C_BR});
      tick(); idle();
      check("memw_stall_cnt", stall_cycles, 32'd5);
      check("memw_flush_cnt", flush_events, 32'd2);
      check("memw_err", {31'd0, mem_err}, 32'd0);

      // Request and ready in the same cycle
      hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
      #1 check("mem_fast_ctl", {24'd0, ctl()}, {24'd0, C_NONE});
      tick(); idle();
      check("mem_fast_stall_cnt", stall_cycles, 32'd5);

      // Timeout: request never completes
      hz.mem_req = 1'b1;
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         #1 check($sformatf("tmo_ctl_%0d", i), {24'd0, ctl()}, {24'd0, C_MEMW});
         tick();
      end
      #1 check("tmo_release_ctl", {24'd0, ctl()}, {24'd0, C_NONE});
      check("tmo_err_before", {31'd0, mem_err}, 32'd0);
      tick(); idle();
      check("tmo_err", {31'd0, mem_err}, 32'd1);
      check("tmo_stall_cnt", stall_cycles, 32'd9);
      // Back in S_RUN: a fresh wait stalls again and releases on ready
      hz.mem_req = 1'b1;
      #1 check("post_tmo_memw_ctl", {24'd0, ctl()}, {24'd0, C_MEMW});
      tick();
      hz.mem_ready = 1'b1;
      #1 check("post_tmo_release_ctl", {24'd0, ctl()}, {24'd0, C_NONE});
      tick(); idle();
      check("post_tmo_stall_cnt", stall_cycles, 32'd10);
      check("post_tmo_err_sticky", {31'd0, mem_err}, 32'd1);

      // Asynchronous reset while in S_MEMW
      hz.mem_req = 1'b1;
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_memw_ctl", {24'd0, ctl()}, {24'd0, C_NONE});
      check("rst_memw_stall_cnt", stall_cycles, 32'd0);
      check("rst_memw_err", {31'd0, mem_err}, 32'd0);
      tick();
      idle();
      rst_n = 1'b1;
      // In S_MEMW, idle mem_req would raise mem_err; in S_RUN it must not
      tick();
      check("rst_state_run_err", {31'd0, mem_err}, 32'd0);
      check("rst_flush_cnt", flush_events, 32'd0);

      // Request dropped without ready while waiting
      hz.mem_req = 1'b1;
      tick();
      hz.mem_req = 1'b0;
      #1 check("drop_ctl", {24'd0, ctl()}, {24'd0, C_NONE});
      tick();
      check("drop_err", {31'd0, mem_err}, 32'd1);
      check("drop_stall_cnt", stall_cycles, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
